// File: rtl/load_queue.sv
// load_queue: in-order load queue between the ACU, the memory read port and the CDB.
// Optional LQ_BYPASS_EN: an allocation into an empty queue issues to memory the same cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module load_queue #(
  parameter int LQ_DEPTH = 4,
  parameter int TAG_W    = `ROB_TAG_LEN
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alloc_valid,
  input  logic [`XLEN-1:0]          alloc_addr,
  input  logic [TAG_W-1:0]          alloc_tag,
  input  logic [2:0]                alloc_size,
  output logic                      alloc_ready,
  input  logic                      pending_stores,
  input  logic                      mem_busy,
  output logic                      mem_req,
  output logic [`XLEN-1:0]          mem_addr,
  output logic [2:0]                mem_size,
  output logic [TAG_W-1:0]          mem_tag,
  input  logic                      mem_resp_valid,
  input  logic [`XLEN-1:0]          mem_resp_data,
  output logic                      done_valid,
  output logic [TAG_W-1:0]          done_tag,
  output logic [`XLEN-1:0]          done_data,
  input  logic                      squash,
  output logic [$clog2(LQ_DEPTH):0] count
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int XL = `XLEN;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(LQ_DEPTH);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ISSUED = 2'd2;

  logic [1:0]       state_q [LQ_DEPTH];
  logic [1:0]       state_d [LQ_DEPTH];
  logic [XL-1:0]    addr_q  [LQ_DEPTH];
  logic [XL-1:0]    addr_d  [LQ_DEPTH];
  logic [TAG_W-1:0] tag_q   [LQ_DEPTH];
  logic [TAG_W-1:0] tag_d   [LQ_DEPTH];
  logic [2:0]       size_q  [LQ_DEPTH];
  logic [2:0]       size_d  [LQ_DEPTH];

  logic [PW-1:0]    head_q, head_d, issue_q, issue_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [PW+1:0]    drop_q, drop_d, issued_left;
  logic             done_valid_q, done_valid_d;
  logic [TAG_W-1:0] done_tag_q, done_tag_d;
  logic [XL-1:0]    done_data_q, done_data_d;

  logic alloc_fire, issue_fire, bypass_fire, retire, drop_resp;

  function automatic logic [XL-1:0] extend(input logic [XL-1:0] d, input logic [2:0] sz);
    case (sz[1:0])
      2'd0:    extend = sz[2] ? {{(XL-8){1'b0}}, d[7:0]}   : {{(XL-8){d[7]}}, d[7:0]};
      2'd1:    extend = sz[2] ? {{(XL-16){1'b0}}, d[15:0]} : {{(XL-16){d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    alloc_ready = (count_q < DEPTH_C);
    alloc_fire  = alloc_valid && alloc_ready && !squash;
    issue_fire  = (state_q[issue_q] == ST_WAIT) && !pending_stores && !mem_busy && !squash;
`ifdef LQ_BYPASS_EN
    bypass_fire = alloc_fire && (count_q == '0) && !pending_stores && !mem_busy;
`else
    bypass_fire = 1'b0;
`endif
    mem_req = issue_fire || bypass_fire;
    if (bypass_fire) begin
      mem_addr = alloc_addr;
      mem_size = alloc_size;
      mem_tag  = alloc_tag;
    end else begin
      mem_addr = addr_q[issue_q];
      mem_size = size_q[issue_q];
      mem_tag  = tag_q[issue_q];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tag_d        = tag_q;
    size_d       = size_q;
    head_d       = head_q;
    issue_d      = issue_q;
    tail_d       = tail_q;
    drop_d       = drop_q;
    issued_left  = '0;
    done_tag_d   = done_tag_q;
    done_data_d  = done_data_q;

    // Responses owed to squashed loads arrive first, so they are consumed before any live one.
    drop_resp    = mem_resp_valid && (drop_q != '0);
    retire       = mem_resp_valid && (drop_q == '0) && (state_q[head_q] == ST_ISSUED);
    done_valid_d = retire && !squash;

    if (drop_resp) drop_d = drop_q - (PW+2)'(1);
    if (retire) begin
      done_tag_d       = tag_q[head_q];
      done_data_d      = extend(mem_resp_data, size_q[head_q]);
      state_d[head_q]  = ST_EMPTY;
      head_d           = head_q + PW'(1);
    end
    if (issue_fire) begin
      state_d[issue_q] = ST_ISSUED;
      issue_d          = issue_q + PW'(1);
    end
    if (alloc_fire) begin
      state_d[tail_q] = bypass_fire ? ST_ISSUED : ST_WAIT;
      addr_d[tail_q]  = alloc_addr;
      tag_d[tail_q]   = alloc_tag;
      size_d[tail_q]  = alloc_size;
      tail_d          = tail_q + PW'(1);
      if (bypass_fire) issue_d = issue_q + PW'(1);
    end
    count_d = count_q + (PW+1)'(alloc_fire) - (PW+1)'(retire);

    // Everything still in flight after this cycle's response becomes a future drop.
    if (squash) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
        if (state_d[i] == ST_ISSUED) issued_left = issued_left + (PW+2)'(1);
        state_d[i] = ST_EMPTY;
      end
      drop_d  = drop_d + issued_left;
      head_d  = '0;
      issue_d = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) state_q[i] <= ST_EMPTY;
      head_q       <= '0;
      issue_q      <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      done_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      issue_q      <= issue_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      done_data_q  <= done_data_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    tag_q  <= tag_d;
    size_q <= size_d;
  end

  assign count      = count_q;
  assign done_valid = done_valid_q;
  assign done_tag   = done_tag_q;
  assign done_data  = done_data_q;

endmodule
